multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control FSM that drives the 16-bit RISC datapath's control inputs from the 4-bit opcode it returns. Each instruction is sequenced over 2–5 clocks. The PC is updated exactly once per instruction, in its final cycle, and a retired-instruction counter is maintained for bring-up. Sits beside the datapath in the CPU top and replaces the combinational single-cycle decoder.

## Interface
- COUNT_WIDTH, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears FSM, latched opcode, counter
- opcode  in  4  instr[15:12] from datapath
- ir_write  out  1  load instruction register (FETCH)
- pc_write  out  1  commit pc_next to PC (last cycle of each instruction)
- jump, beq, bne  out  1 each  PC-select controls to datapath
- mem_read, mem_write  out  1 each  data-memory strobes
- alu_src, reg_dst, mem_to_reg, reg_write  out  1 each  datapath mux/write controls
- alu_op  out  3  ALU function
- state  out  3  current FSM state (debug)
- illegal  out  1  one-cycle pulse on undefined opcode
- instr_retired  out  COUNT_WIDTH  count of completed instructions, wraps

## Operation
- Opcode map:
  - 0000 LD; 0001 ST
  - 0010 ADD; 0011 SUB; 0100 INV; 0101 LSL; 0110 LSR; 0111 AND; 1000 OR; 1001 SLT
  - 1011 BEQ; 1100 BNE; 1101 JMP
  - 1010, 1110, 1111 illegal
- alu_op:
  - ADD/LD/ST=000, SUB=001, INV=010, LSL=011, LSR=100, AND=101, OR=110, SLT=111
  - BEQ/BNE=001
  - 000 in FETCH, in DECODE, and for illegal opcodes
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5–7 go to FETCH next cycle with all outputs 0.
- FETCH: ir_write=1; next DECODE.
- DECODE: decodes `opcode` input directly; op_q <= opcode on the exiting edge.
  - JMP: jump=1, pc_write=1; next FETCH.
  - Illegal: illegal=1, pc_write=1 (PC+1, no other effect); next FETCH.
  - Otherwise next EXEC.
- EXEC (decodes op_q):
  - R-type (0010–1001): alu_op per map; next WB.
  - LD/ST: alu_src=1, alu_op=000; next MEM.
  - BEQ: beq=1, alu_op=001, pc_write=1; next FETCH. BNE: same with bne=1. The datapath's zero flag selects branch target vs PC+1.
- MEM:
  - LD: alu_src=1, mem_read=1; next WB.
  - ST: alu_src=1, mem_write=1, pc_write=1; next FETCH.
- WB:
  - R-type: reg_dst=1, alu_op held, reg_write=1, pc_write=1.
  - LD: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, pc_write=1.
  - Next FETCH in both cases.
- Any control not listed for a state is 0.
- instr_retired increments on every clock where pc_write=1 (illegal included). Wraps 2^COUNT_WIDTH−1 → 0.

## Timing
- All outputs are combinational from state, op_q and, in DECODE only, `opcode`. state, op_q and instr_retired are registered.
- Reset values: state=FETCH, op_q=0, instr_retired=0. While reset is high, ir_write is forced to 0 and every other control output is 0.
- First ir_write is in the first cycle after reset deasserts.
- Cycles per instruction: JMP 2, illegal 2, BEQ/BNE 3, R-type 4, ST 4, LD 5.
- pc_write is high for exactly one cycle per instruction, always in the final cycle. reg_write and mem_write are never high in the same cycle.
- Reset asserted mid-instruction aborts immediately: no pc_write, reg_write or mem_write occurs after the asserting edge, and the counter is cleared.
- The opcode input is ignored outside DECODE, so datapath changes to instr after FETCH have no effect.

## Test plan
- Reset, then program ADD: state sequence 0,1,2,4,0; reg_write=1 and reg_dst=1 only in WB; pc_write only in WB; instr_retired=1.
- LD then ST: LD gives mem_read in MEM and WB, and mem_to_reg=reg_write=1 in WB (5 cycles). ST gives mem_write=1 only in MEM (4 cycles). alu_op=000 throughout; counter=2.
- BEQ then BNE then JMP: beq+pc_write in cycle 3 with alu_op=001; bne likewise; jump+pc_write in cycle 2; total 8 cycles; counter=3.
- Opcode 1110: illegal=1 and pc_write=1 in DECODE; no reg_write or mem_write; back to FETCH; counter increments.
- Reset asserted during MEM of ST: mem_write drops at once, state=0, counter=0; after release, ir_write=1 on the next cycle.
- COUNT_WIDTH=4, run 17 JMPs: counter reads 15 then 0 then 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC datapath.
// Sequences each instruction over 2-5 clocks, commits the PC once per
// instruction in its final cycle and counts retired instructions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | load instruction register
// DECODE | decode live opcode; JMP and illegal opcodes retire here
// EXEC   | ALU operation / address calc / branch resolve (uses op_q)
// MEM    | data memory access (LD read, ST write + retire)
// WB     | register write-back and retire (R-type, LD)
// 5..7   | unreachable; all outputs 0, recover to FETCH
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             opcode,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   jump,
  output logic                   beq,
  output logic                   bne,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   alu_src,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic [2:0]             alu_op,
  output logic [2:0]             state,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] op_q;
  logic       ir_write_raw;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'b0010) && (op <= 4'b1001);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  // R-type opcodes 0010..1001 map to ALU functions 000..111 in order
  function automatic logic [2:0] rtype_alu_op(input logic [3:0] op);
    logic [3:0] idx;
    idx = op - 4'b0010;
    return idx[2:0];
  endfunction

  // State, latched opcode and retired counter; reset aborts any instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      op_q          <= 4'b0000;
      instr_retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        op_q <= opcode;
      if (pc_write)
        instr_retired <= instr_retired + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and control decode; every control defaults to 0
  always_comb begin
    state_d      = FETCH;
    ir_write_raw = 1'b0;
    pc_write     = 1'b0;
    jump         = 1'b0;
    beq          = 1'b0;
    bne          = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_op       = 3'b000;
    illegal      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write_raw = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        if (opcode == OP_JMP) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end else if (is_illegal(opcode)) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_rtype(op_q)) begin
          alu_op  = rtype_alu_op(op_q);
          state_d = WB;
        end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
          alu_src = 1'b1;
          state_d = MEM;
        end else if (op_q == OP_BEQ) begin
          beq      = 1'b1;
          alu_op   = 3'b001;
          pc_write = 1'b1;
        end else if (op_q == OP_BNE) begin
          bne      = 1'b1;
          alu_op   = 3'b001;
          pc_write = 1'b1;
        end
      end
      MEM: begin
        if (op_q == OP_LD) begin
          alu_src  = 1'b1;
          mem_read = 1'b1;
          state_d  = WB;
        end else if (op_q == OP_ST) begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
          pc_write  = 1'b1;
        end
      end
      WB: begin
        if (is_rtype(op_q)) begin
          reg_dst   = 1'b1;
          alu_op    = rtype_alu_op(op_q);
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end else if (op_q == OP_LD) begin
          alu_src    = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          pc_write   = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FETCH is the reset state, so ir_write must be masked while reset is held
  assign ir_write = ir_write_raw & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (counter narrowed to 4 bits
// so the wrap case is reachable quickly).
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam logic [11:0] IRW  = 12'h800;
  localparam logic [11:0] PCW  = 12'h400;
  localparam logic [11:0] JMP  = 12'h200;
  localparam logic [11:0] BEQ  = 12'h100;
  localparam logic [11:0] BNE  = 12'h080;
  localparam logic [11:0] MRD  = 12'h040;
  localparam logic [11:0] MWR  = 12'h020;
  localparam logic [11:0] ASRC = 12'h010;
  localparam logic [11:0] RDST = 12'h008;
  localparam logic [11:0] MTR  = 12'h004;
  localparam logic [11:0] RW   = 12'h002;
  localparam logic [11:0] ILL  = 12'h001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = 4'b0000;
  logic          ir_write, pc_write, jump, beq, bne, mem_read, mem_write;
  logic          alu_src, reg_dst, mem_to_reg, reg_write, illegal;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] instr_retired;
  logic [17:0]   obs;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .ir_write(ir_write), .pc_write(pc_write), .jump(jump), .beq(beq), .bne(bne),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .state(state), .illegal(illegal),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  assign obs = {state, alu_op, ir_write, pc_write, jump, beq, bne, mem_read,
                mem_write, alu_src, reg_dst, mem_to_reg, reg_write, illegal};

  function automatic logic [17:0] ex(input logic [2:0] s, input logic [2:0] a,
                                     input logic [11:0] c);
    return {s, a, c};
  endfunction

  // Leaves time just after a falling edge with the FSM in FETCH
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0);
    end
    checks++;
    if (instr_retired !== 4'd0) begin
      errors++;
      $display("FAIL reset_counter: got %0d expected 0", instr_retired);
    end
  endtask

  task automatic test_add();
    logic [17:0] ev [4];
    ev[0] = ex(3'd0, 3'd0, IRW);
    ev[1] = ex(3'd1, 3'd0, 12'h0);
    ev[2] = ex(3'd2, 3'd0, 12'h0);
    ev[3] = ex(3'd4, 3'd0, PCW | RDST | RW);
    do_reset();
    opcode = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL add_cycle%0d: got %h expected %h", i, obs, ev[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (obs !== ex(3'd0, 3'd0, IRW) || instr_retired !== 4'd1) begin
      errors++;
      $display("FAIL add_end: got %h cnt %0d expected %h cnt 1", obs, instr_retired, ex(3'd0, 3'd0, IRW));
    end
  endtask

  // All R-types back to back; opcode is scrambled after DECODE and must be ignored
  task automatic test_rtype_all();
    logic [2:0] aop;
    do_reset();
    for (int op = 2; op <= 9; op++) begin
      aop = 3'(op - 2);
      opcode = 4'(op);
      for (int c = 0; c < 4; c++) begin
        logic [17:0] e;
        case (c)
          0: e = ex(3'd0, 3'd0, IRW);
          1: e = ex(3'd1, 3'd0, 12'h0);
          2: e = ex(3'd2, aop, 12'h0);
          default: e = ex(3'd4, aop, PCW | RDST | RW);
        endcase
        if (c == 2) opcode = 4'b1101;
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rtype_op%0d_cycle%0d: got %h expected %h", op, c, obs, e);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (instr_retired !== 4'd8) begin
      errors++;
      $display("FAIL rtype_count: got %0d expected 8", instr_retired);
    end
  endtask

  task automatic test_ld_st();
    logic [17:0] ev [9];
    logic [3:0]  opv [9];
    ev[0] = ex(3'd0, 3'd0, IRW);             opv[0] = 4'b0000;
    ev[1] = ex(3'd1, 3'd0, 12'h0);           opv[1] = 4'b0000;
    ev[2] = ex(3'd2, 3'd0, ASRC);            opv[2] = 4'b0000;
    ev[3] = ex(3'd3, 3'd0, ASRC | MRD);      opv[3] = 4'b0000;
    ev[4] = ex(3'd4, 3'd0, ASRC | MRD | MTR | RW | PCW); opv[4] = 4'b0000;
    ev[5] = ex(3'd0, 3'd0, IRW);             opv[5] = 4'b0001;
    ev[6] = ex(3'd1, 3'd0, 12'h0);           opv[6] = 4'b0001;
    ev[7] = ex(3'd2, 3'd0, ASRC);            opv[7] = 4'b0001;
    ev[8] = ex(3'd3, 3'd0, ASRC | MWR | PCW); opv[8] = 4'b0001;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      opcode = opv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL ldst_cycle%0d: got %h expected %h", i, obs, ev[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (obs !== ex(3'd0, 3'd0, IRW) || instr_retired !== 4'd2) begin
      errors++;
      $display("FAIL ldst_end: got %h cnt %0d expected %h cnt 2", obs, instr_retired, ex(3'd0, 3'd0, IRW));
    end
  endtask

  task automatic test_branches();
    logic [17:0] ev [8];
    logic [3:0]  opv [8];
    ev[0] = ex(3'd0, 3'd0, IRW);       opv[0] = 4'b1011;
    ev[1] = ex(3'd1, 3'd0, 12'h0);     opv[1] = 4'b1011;
    ev[2] = ex(3'd2, 3'd1, BEQ | PCW); opv[2] = 4'b1011;
    ev[3] = ex(3'd0, 3'd0, IRW);       opv[3] = 4'b1100;
    ev[4] = ex(3'd1, 3'd0, 12'h0);     opv[4] = 4'b1100;
    ev[5] = ex(3'd2, 3'd1, BNE | PCW); opv[5] = 4'b1100;
    ev[6] = ex(3'd0, 3'd0, IRW);       opv[6] = 4'b1101;
    ev[7] = ex(3'd1, 3'd0, JMP | PCW); opv[7] = 4'b1101;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = opv[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL branch_cycle%0d: got %h expected %h", i, obs, ev[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (obs !== ex(3'd0, 3'd0, IRW) || instr_retired !== 4'd3) begin
      errors++;
      $display("FAIL branch_end: got %h cnt %0d expected %h cnt 3", obs, instr_retired, ex(3'd0, 3'd0, IRW));
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    ops[0] = 4'b1110;
    ops[1] = 4'b1010;
    ops[2] = 4'b1111;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      #1;
      checks++;
      if (obs !== ex(3'd0, 3'd0, IRW)) begin
        errors++;
        $display("FAIL illegal_%b_fetch: got %h expected %h", ops[k], obs, ex(3'd0, 3'd0, IRW));
      end
      @(negedge clk);
      checks++;
      if (obs !== ex(3'd1, 3'd0, ILL | PCW)) begin
        errors++;
        $display("FAIL illegal_%b_decode: got %h expected %h", ops[k], obs, ex(3'd1, 3'd0, ILL | PCW));
      end
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || instr_retired !== 4'(k + 1)) begin
        errors++;
        $display("FAIL illegal_%b_after: state %0d cnt %0d expected state 0 cnt %0d", ops[k], state, instr_retired, k + 1);
      end
    end
  endtask

  task automatic test_reset_mid_st();
    do_reset();
    opcode = 4'b1101;
    @(negedge clk);
    @(negedge clk);
    opcode = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== ex(3'd3, 3'd0, ASRC | MWR | PCW) || instr_retired !== 4'd1) begin
      errors++;
      $display("FAIL midrst_pre: got %h cnt %0d expected %h cnt 1", obs, instr_retired, ex(3'd3, 3'd0, ASRC | MWR | PCW));
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0 || instr_retired !== 4'd0) begin
      errors++;
      $display("FAIL midrst_assert: got %h cnt %0d expected 0 cnt 0", obs, instr_retired);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 18'h0 || instr_retired !== 4'd0) begin
      errors++;
      $display("FAIL midrst_held: got %h cnt %0d expected 0 cnt 0", obs, instr_retired);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== ex(3'd0, 3'd0, IRW)) begin
      errors++;
      $display("FAIL midrst_release: got %h expected %h", obs, ex(3'd0, 3'd0, IRW));
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || instr_retired !== 4'd0) begin
      errors++;
      $display("FAIL midrst_next: state %0d cnt %0d expected state 1 cnt 0", state, instr_retired);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    opcode = 4'b1101;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      @(negedge clk);
      if (k >= 15) begin
        checks++;
        if (instr_retired !== 4'(k % 16)) begin
          errors++;
          $display("FAIL wrap_after_%0d: got %0d expected %0d", k, instr_retired, k % 16);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_rtype_all();
    test_ld_st();
    test_branches();
    test_illegal();
    test_reset_mid_st();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
